// File: rtl/mux_bus4_pkg.sv
// Shared widths, lane type and lane-extraction helper for the mux_bus4 slice.
package mux_bus4_pkg;

  localparam int unsigned LANES_DEF  = 8;
  localparam int unsigned LANE_W_DEF = 4;
  localparam int unsigned SEL_W_DEF  = $clog2(LANES_DEF);
  localparam int unsigned BUS_W_DEF  = LANES_DEF * LANE_W_DEF;

  typedef logic [LANE_W_DEF-1:0] lane_t;

  // Returns lane idx of a default-geometry packed bus (lane 0 in the LSBs).
  function automatic lane_t lane_of(input logic [BUS_W_DEF-1:0] bus,
                                    input logic [SEL_W_DEF-1:0] idx);
    lane_of = bus[32'(idx) * LANE_W_DEF +: LANE_W_DEF];
  endfunction

endpackage

// File: rtl/mux_bus4_sel.sv
// Combinational LANES:1 lane selector; out-of-range indices yield zero.
module mux_bus4_sel
  import mux_bus4_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF,
  localparam int unsigned SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*LANE_W-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [LANE_W-1:0]       lane,
  output logic                    in_range
);

  // One-hot compare against every lane index; exactly one match for a valid sel.
  always_comb begin
    lane     = '0;
    in_range = 1'b0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (sel == SEL_W'(k)) begin
        lane     = in_bus[k*LANE_W +: LANE_W];
        in_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_bus4.sv
// Registered 8:1 multiplexer over a packed bus of 4-bit lanes, one-cycle latency.
module mux_bus4
  import mux_bus4_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF,
  localparam int unsigned SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*LANE_W-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic [LANE_W-1:0]       out,
  output logic                    out_valid
);

  logic [LANE_W-1:0] sel_lane;
  logic              sel_in_range;

  mux_bus4_sel #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_sel (
    .in_bus   (in_bus),
    .sel      (sel),
    .lane     (sel_lane),
    .in_range (sel_in_range)
  );

  // Capture the selected lane on in_valid; out holds otherwise, out_valid pulses per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= sel_in_range ? sel_lane : '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_bus4.sv
// Scoreboard bench for mux_bus4: expected lanes queued at drive time, popped on out_valid.
module tb_mux_bus4;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_bus;
  logic [2:0]  sel;
  logic        in_valid;
  logic [3:0]  out;
  logic        out_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [3:0] lane_tab [8] = '{4'd12, 4'd15, 4'd1, 4'd3, 4'd5, 4'd2, 4'd11, 4'd14};
  logic [3:0] sb_q [$];
  logic [3:0] exp_out;

  localparam logic [31:0] BUS_PAT = 32'hEB25_31FC;

  mux_bus4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 ns after the capturing edge.
  task automatic step(input logic v, input logic [2:0] s, input string tag);
    in_valid = v;
    sel      = s;
    if (v) sb_q.push_back(lane_tab[s]);
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) check({tag, "_sb_underflow"}, 32'd1, 32'd0);
      else exp_out = sb_q.pop_front();
    end
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_out"}, 32'(out), 32'(exp_out));
  endtask

  initial begin
    exp_out  = 4'd0;
    rst_n    = 1'b0;
    in_bus   = BUS_PAT;
    sel      = 3'd3;
    in_valid = 1'b1;

    // Reset asserted with active inputs, before any clock edge.
    #3;
    check("rst_noclk_out", 32'(out), 32'd0);
    check("rst_noclk_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("rst_held_out", 32'(out), 32'd0);
    check("rst_held_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 3'd3, "post_rst");

    // Select sweep, back-to-back.
    step(1'b1, 3'd3, "sweep3");
    step(1'b1, 3'd5, "sweep5");
    step(1'b1, 3'd7, "sweep7");
    step(1'b1, 3'd0, "sweep0");
    step(1'b1, 3'd2, "sweep2");

    // Full lane coverage.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), $sformatf("full%0d", i));

    // Hold: capture lane 7 then change inputs with in_valid low.
    step(1'b1, 3'd7, "hold_cap");
    check("hold_cap_is14", 32'(out), 32'd14);
    in_bus = $urandom();
    step(1'b0, 3'd2, "hold1");
    in_bus = $urandom();
    step(1'b0, 3'd5, "hold2");
    in_bus = BUS_PAT;

    // Async reset mid-stream with a capture pending.
    step(1'b1, 3'd4, "pre_rst");
    check("pre_rst_is5", 32'(out), 32'd5);
    in_valid = 1'b1;
    sel      = 3'd6;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    exp_out = 4'd0;
    @(posedge clk); #1;
    check("mid_rst_edge_out", 32'(out), 32'd0);
    check("mid_rst_edge_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 3'd6, "rel_idle");
    step(1'b1, 3'd1, "rel_sel1");
    check("rel_sel1_is15", 32'(out), 32'd15);

    // Between-edge glitching of sel with in_valid low.
    in_valid = 1'b0;
    sel = 3'd0; #2;
    sel = 3'd7; #2;
    sel = 3'd0;
    @(posedge clk); #1;
    check("glitch_out", 32'(out), 32'd15);
    check("glitch_valid", 32'(out_valid), 32'd0);

    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
